// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: one-hot state encodings and frame field widths.
// The testbench stream source reuses these encodings.
package boot_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int LEN_W  = 16;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [7:0] {
    ST_LEN_HI = 8'b0000_0001,
    ST_LEN_LO = 8'b0000_0010,
    ST_DAT_HI = 8'b0000_0100,
    ST_DAT_LO = 8'b0000_1000,
    ST_WRITE  = 8'b0001_0000,
    ST_CSUM   = 8'b0010_0000,
    ST_DONE   = 8'b0100_0000,
    ST_ERR    = 8'b1000_0000
  } state_e;

  // States that take a stream byte; WRITE, DONE and ERR refuse input.
  function automatic logic accepts_bytes(input state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DAT_HI) ||
           (s == ST_DAT_LO) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input, memory write port and CPU control of the boot loader.
interface boot_loader_if;
  import boot_loader_pkg::*;

  logic                  in_valid;
  logic [BYTE_W-1:0]     in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [WORD_W-1:0]     mem_wdata;
  logic                  cpu_rst;
  logic                  done;
  logic                  error;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, error
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, error
  );

endinterface

// File: rtl/boot_loader_csum8.sv
// 8-bit running modulo-256 sum of accepted bytes; zero_next previews whether
// adding the current byte would bring the sum to zero.
module csum8
  import boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [BYTE_W-1:0] sum,
  output logic              zero_next
);

  logic [BYTE_W-1:0] sum_q, sum_d, sum_next;

  always_comb begin
    sum_next = sum_q + byte_in;
    sum_d    = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (add) begin
      sum_d = sum_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum       = sum_q;
  assign zero_next = (sum_next == '0);

endmodule

// File: rtl/boot_loader.sv
// Loads a length-prefixed, checksummed image from a byte stream into memory
// and holds the CPU in reset until the whole image has arrived intact.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
  parameter logic [LEN_W-1:0]  MAX_WORDS = 16'h0400
) (
  input  logic          clk,
  input  logic          rst,
  boot_loader_if.slave  bus
);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                in_ready;
  logic                xfer;
  logic [LEN_W-1:0]    len_new;
  logic [LEN_W-1:0]    cnt_inc;
  logic                csum_zero_next;
  logic [BYTE_W-1:0]   csum_sum_unused;

  assign in_ready = accepts_bytes(state_q);
  assign xfer     = bus.in_valid & in_ready;
  assign len_new  = {len_q[LEN_W-1:BYTE_W], bus.in_data};
  assign cnt_inc  = cnt_q + 16'd1;

  csum8 u_csum (
    .clk       (clk),
    .rst       (rst),
    .clr       (1'b0),
    .add       (xfer),
    .byte_in   (bus.in_data),
    .sum       (csum_sum_unused),
    .zero_next (csum_zero_next)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    error_d   = error_q;

    case (state_q)
      ST_LEN_HI: begin
        if (xfer) begin
          len_d   = {bus.in_data, len_q[BYTE_W-1:0]};
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (xfer) begin
          len_d = len_new;
          if (len_new > MAX_WORDS) begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end else if (len_new == '0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DAT_HI;
          end
        end
      end
      ST_DAT_HI: begin
        if (xfer) begin
          wdata_d = {bus.in_data, wdata_q[BYTE_W-1:0]};
          state_d = ST_DAT_LO;
        end
      end
      ST_DAT_LO: begin
        if (xfer) begin
          wdata_d = {wdata_q[WORD_W-1:BYTE_W], bus.in_data};
          we_d    = 1'b1;
          state_d = ST_WRITE;
        end
      end
      // The strobe cycle: address advances only after the word is committed.
      ST_WRITE: begin
        addr_d  = addr_q + 16'd1;
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == len_q) ? ST_CSUM : ST_DAT_HI;
      end
      ST_CSUM: begin
        if (xfer) begin
          if (csum_zero_next) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_DONE;
      ST_ERR:  state_d = ST_ERR;
      default: begin
        state_d = ST_ERR;
        error_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_LEN_HI;
      len_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= BASE_ADDR;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_rst   = cpu_rst_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed testbench for boot_loader: good/bad/zero/oversize frames, stalls
// and mid-load reset, against a small memory model fed by the write port.
module tb_boot_loader;
  import boot_loader_pkg::*;

  typedef logic [7:0] byte_q_t[$];

  logic clk;
  logic rst;
  logic tb_valid;
  logic [7:0] tb_data;
  logic sel_b;
  logic ready_mux;

  int total;
  int bad;

  logic [15:0] mem_a [logic [15:0]];
  logic [15:0] log_addr[$];
  logic [15:0] log_data[$];
  int we_count_b;
  int xfer_count_a;
  logic done_at_accept;
  bit rst_done_bad;
  bit write_ready_bad;

  boot_loader_if bus_a ();
  boot_loader_if bus_b ();

  assign bus_a.in_valid = tb_valid & ~sel_b;
  assign bus_b.in_valid = tb_valid & sel_b;
  assign bus_a.in_data  = tb_data;
  assign bus_b.in_data  = tb_data;
  assign ready_mux      = sel_b ? bus_b.in_ready : bus_a.in_ready;

  boot_loader dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  boot_loader #(.MAX_WORDS(16'h0008)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model and transfer accounting, updated on the active edge.
  always @(posedge clk) begin
    if (bus_a.mem_we) begin
      mem_a[bus_a.mem_addr] = bus_a.mem_wdata;
      log_addr.push_back(bus_a.mem_addr);
      log_data.push_back(bus_a.mem_wdata);
    end
    if (bus_b.mem_we) we_count_b++;
    if (bus_a.in_valid && bus_a.in_ready) xfer_count_a++;
  end

  // cpu_rst must be exactly the inverse of done, and no byte may be taken in a write cycle.
  always @(negedge clk) begin
    if (bus_a.cpu_rst !== ~bus_a.done) rst_done_bad = 1'b1;
    if (bus_a.mem_we && bus_a.in_ready) write_ready_bad = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    bit accepted;
    int guard;
    accepted = 1'b0;
    guard    = 0;
    while (!accepted && guard < 60) begin
      tb_data  = b;
      tb_valid = stall ? ($urandom_range(1, 0) == 1) : 1'b1;
      accepted = tb_valid && ready_mux;
      done_at_accept = sel_b ? bus_b.done : bus_a.done;
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    if (!accepted) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input byte_q_t q, input bit stall);
    foreach (q[i]) send_byte(q[i], stall);
    tb_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    log_addr.delete();
    log_data.delete();
    we_count_b   = 0;
    xfer_count_a = 0;
    @(negedge clk);
  endtask

  task automatic check_good_image(input string tag);
    check({tag, "_writes"}, log_addr.size(), 32'd2);
    if (log_addr.size() == 2) begin
      check({tag, "_addr0"}, log_addr[0], 32'h0000);
      check({tag, "_data0"}, log_data[0], 32'h1234);
      check({tag, "_addr1"}, log_addr[1], 32'h0001);
      check({tag, "_data1"}, log_data[1], 32'hABCD);
    end
    check({tag, "_done"},    bus_a.done,    32'd1);
    check({tag, "_cpu_rst"}, bus_a.cpu_rst, 32'd0);
    check({tag, "_error"},   bus_a.error,   32'd0);
  endtask

  initial begin
    int ready_hits;
    total = 0;
    bad = 0;
    rst = 1'b1;
    tb_valid = 1'b0;
    tb_data = 8'h00;
    sel_b = 1'b0;
    we_count_b = 0;
    xfer_count_a = 0;
    done_at_accept = 1'b0;
    rst_done_bad = 1'b0;
    write_ready_bad = 1'b0;

    // Reset values while rst is held.
    repeat (2) @(negedge clk);
    check("rst_mem_we",    bus_a.mem_we,    32'd0);
    check("rst_mem_addr",  bus_a.mem_addr,  32'h0000);
    check("rst_mem_wdata", bus_a.mem_wdata, 32'h0000);
    check("rst_cpu_rst",   bus_a.cpu_rst,   32'd1);
    check("rst_done",      bus_a.done,      32'd0);
    check("rst_error",     bus_a.error,     32'd0);
    check("rst_in_ready",  bus_a.in_ready,  32'd1);
    do_reset();

    // 1: good two-word load, valid held high.
    send_frame('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD}, 1'b0);
    check("t1_mem_we_last", bus_a.mem_we, 32'd1);
    check("t1_in_ready_write", bus_a.in_ready, 32'd0);
    send_frame('{8'h40}, 1'b0);
    check("t1_done_before", done_at_accept, 32'd0);
    check_good_image("t1");
    check("t1_xfers", xfer_count_a, 32'd7);

    // 2: bad checksum ends in a terminal error.
    do_reset();
    send_frame('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41}, 1'b0);
    check("t2_writes",  log_addr.size(), 32'd2);
    check("t2_error",   bus_a.error,     32'd1);
    check("t2_cpu_rst", bus_a.cpu_rst,   32'd1);
    check("t2_done",    bus_a.done,      32'd0);
    ready_hits = 0;
    tb_valid = 1'b1;
    tb_data  = 8'h00;
    for (int i = 0; i < 10; i++) begin
      if (bus_a.in_ready) ready_hits++;
      @(negedge clk);
    end
    tb_valid = 1'b0;
    check("t2_ready_after_err", ready_hits, 32'd0);
    check("t2_xfers", xfer_count_a, 32'd7);

    // 3: zero-length image.
    do_reset();
    send_frame('{8'h00, 8'h00, 8'h00}, 1'b0);
    check("t3_writes",  log_addr.size(), 32'd0);
    check("t3_done",    bus_a.done,      32'd1);
    check("t3_cpu_rst", bus_a.cpu_rst,   32'd0);

    // 4: MAX_WORDS=8 instance; 9 words is a framing error, 8 is accepted.
    sel_b = 1'b1;
    do_reset();
    send_frame('{8'h00, 8'h09}, 1'b0);
    check("t4_error",    bus_b.error,    32'd1);
    check("t4_in_ready", bus_b.in_ready, 32'd0);
    check("t4_done",     bus_b.done,     32'd0);
    check("t4_cpu_rst",  bus_b.cpu_rst,  32'd1);
    check("t4_writes",   we_count_b,     32'd0);
    do_reset();
    send_frame('{8'h00, 8'h08}, 1'b0);
    check("t4_max_error", bus_b.error,    32'd0);
    check("t4_max_ready", bus_b.in_ready, 32'd1);
    sel_b = 1'b0;

    // 5: good load with random stalls on in_valid.
    do_reset();
    send_frame('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40}, 1'b1);
    check_good_image("t5");
    check("t5_xfers", xfer_count_a, 32'd7);

    // 6: reset during the third word's write cycle, then a fresh one-word image.
    do_reset();
    send_frame('{8'h00, 8'h04, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33}, 1'b0);
    check("t6_in_write", bus_a.mem_we, 32'd1);
    rst = 1'b1;
    #1;
    check("t6_we_async_drop", bus_a.mem_we,   32'd0);
    check("t6_cpu_rst_held",  bus_a.cpu_rst,  32'd1);
    check("t6_addr_reset",    bus_a.mem_addr, 32'h0000);
    do_reset();
    send_frame('{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h52}, 1'b0);
    check("t6_writes", log_addr.size(), 32'd1);
    check("t6_mem0",   mem_a.exists(16'h0000) ? mem_a[16'h0000] : 16'hxxxx, 32'h0000BEEF);
    check("t6_done",   bus_a.done, 32'd1);

    check("cpu_rst_vs_done", rst_done_bad,    32'd0);
    check("ready_in_write",  write_ready_bad, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
